sat_corr: RTL and testbench
===========================

# sat_corr

Single-channel tracking correlator, the receive-side counterpart of the per-SV signal generator. It wipes off a local carrier from the complex baseband sample stream and despreads with the selected C/A chip. It then integrates and dumps complex sums over a programmable number of samples. One instance sits per tracked SV after the sample front end, feeding dump results to the tracking-loop processor via a valid/ready handshake.

## Interface
Parameters:
- IN_W, 16: signed width of `real_in` / `imag_in`.
- ACC_W, 32: signed width of accumulators and dump outputs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample strobe; `real_in`/`imag_in`/chip are consumed on edges where `enable`=1.
- real_in  in  IN_W  signed in-phase sample.
- imag_in  in  IN_W  signed quadrature sample.
- freq  in  32  carrier NCO phase increment per accepted sample.
- ca_seq  in  36  C/A chip bits from the shared code generator.
- ca_sel  in  6  index into `ca_seq`; chip = `ca_seq[ca_sel]`, 1 means ×(-1).
- dump_len  in  16  samples per integration, 0 treated as 1.
- i_dump  out  ACC_W  signed integrated in-phase result.
- q_dump  out  ACC_W  signed integrated quadrature result.
- dump_valid  out  1  result pending.
- dump_ready  in  1  consumer accepts result.
- overrun  out  1  sticky: a pending result was overwritten.

## Operation
- Carrier NCO: 32-bit phase accumulator `phase`; index k = `phase[31:29]` before update; `phase += freq` (mod 2^32) on each accepted sample.
- Carrier LUT, k=0..7: cos = 2,1,-1,-2,-2,-1,1,2; sin = 1,2,2,1,-1,-2,-2,-1.
- Stage 1 (edge accepting sample): register I1 = real·cos + imag·sin, Q1 = imag·cos − real·sin (IN_W+3 bits signed, exact), chip bit, last-flag, and valid bit.
- Stage 2 (next edge, stage-1 valid): term = chip ? −(I1,Q1) : (I1,Q1), sign-extended to ACC_W. Accumulators add term with two's-complement wrap and no saturation.
- Sample counter: counts accepted samples 0..L−1. L is `dump_len` latched when count=0, with 0→1. Sample at count L−1 sets last-flag and the counter returns to 0.
- Dump (stage 2 with last-flag): `i_dump`/`q_dump` ← acc+term; accumulators ← 0; `dump_valid` ← 1.
- Handshake: on an edge with `dump_valid`=1 and `dump_ready`=1 and no new dump, `dump_valid` ← 0.
  - New dump while `dump_valid`=1 and `dump_ready`=0: outputs overwritten, `dump_valid` stays 1, `overrun` ← 1.
  - New dump on the same edge as a handshake: new result loaded, `dump_valid` stays 1, no overrun.
- `overrun` clears only on reset.
- `enable`=0: phase, counter and stage-1 inputs hold. The stage-1 valid bit clears so that no term is added twice.

## Timing
- Reset (any cycle, including mid-integration) clears `phase`, counter, latched L, accumulators, stage-1 valid, `i_dump`=0, `q_dump`=0, `dump_valid`=0, `overrun`=0. A partial integration is discarded.
- Latency: the last sample is accepted on edge E0, and `dump_valid`/results update on edge E0+1 (2-stage pipeline).
- Throughput: one sample per clock. With L=1 and `dump_ready`=1, a new dump appears every cycle.
- A `dump_len` change takes effect at the next integration start only.
- `freq`, `ca_sel` and `ca_seq` are sampled on the accepting edge only.

## Test plan
- freq=0, real_in=100, imag_in=0, chip=0, dump_len=4, 4 strobes → `i_dump`=800, `q_dump`=-400, `dump_valid`=1 one edge after the 4th strobe.
- Same stimulus with chip=1 → `i_dump`=-800, `q_dump`=400.
- freq=0x2000_0000, real_in=1000, imag_in=0, dump_len=8 → k cycles 0..7, `i_dump`=0, `q_dump`=0.
- dump_len=2, `dump_ready`=0, 4 strobes → `overrun`=1, outputs hold the second result, `dump_valid`=1; assert `dump_ready` for one cycle → `dump_valid`=0, `overrun` stays 1.
- dump_len=4, 3 strobes, reset, then 4 strobes of real_in=100 (freq=0) → `i_dump`=800 with no residue from the aborted integration, and `dump_valid` stays 0 until the 4th post-reset strobe.
- dump_len=1, `enable` and `dump_ready` held high, real_in stepping 1,2,3 → `i_dump`=2,4,6 on consecutive cycles and `overrun`=0.

Source files
------------

// File: rtl/sat_corr_if.sv
// -----------------------------------------------------------------------------
// sat_corr_if
// Dump result channel between a tracking correlator and the tracking-loop
// processor. The producer (master) presents a signed I/Q integration result
// with dump_valid; the consumer (slave) accepts it with dump_ready.
//   i_dump, q_dump : signed ACC_W-bit integrated in-phase / quadrature result
//   dump_valid     : a result is pending
//   dump_ready     : consumer accepts the pending result this cycle
// -----------------------------------------------------------------------------
interface sat_corr_if #(
  parameter int ACC_W = 32
);
  logic signed [ACC_W-1:0] i_dump;
  logic signed [ACC_W-1:0] q_dump;
  logic                    dump_valid;
  logic                    dump_ready;

  modport master (
    output i_dump,
    output q_dump,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  i_dump,
    input  q_dump,
    input  dump_valid,
    output dump_ready
  );
endinterface

// File: rtl/sat_corr.sv
// -----------------------------------------------------------------------------
// sat_corr
// Single-channel tracking correlator. Each accepted sample is rotated by a
// coarse 8-step local carrier (NCO + LUT), despread by the selected C/A chip,
// and integrated over dump_len samples; the complex sum is then dumped to the
// tracking-loop processor over a valid/ready channel.
//   clk, reset          : system clock, synchronous active-high reset
//   enable              : sample strobe
//   real_in, imag_in    : signed IN_W-bit complex baseband sample
//   freq                : carrier NCO phase increment per accepted sample
//   ca_seq, ca_sel      : shared C/A chip bits and the index of this channel's chip
//   dump_len            : samples per integration (0 behaves as 1)
//   dump                : dump result channel (master side)
//   overrun             : sticky, a pending result was overwritten
// -----------------------------------------------------------------------------
module sat_corr #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic signed [IN_W-1:0] real_in,
  input  logic signed [IN_W-1:0] imag_in,
  input  logic [31:0]            freq,
  input  logic [35:0]            ca_seq,
  input  logic [5:0]             ca_sel,
  input  logic [15:0]            dump_len,
  sat_corr_if.master             dump,
  output logic                   overrun
);

  // Rotated sample width: |2*x| + |2*y| fits exactly in IN_W+3 signed bits.
  localparam int P_W = IN_W + 3;

  typedef logic signed [2:0] lut_t;

  function automatic lut_t cos_lut(input logic [2:0] k);
    case (k)
      3'd0, 3'd7: return 3'sd2;
      3'd1, 3'd6: return 3'sd1;
      3'd2, 3'd5: return -3'sd1;
      default:    return -3'sd2;
    endcase
  endfunction

  function automatic lut_t sin_lut(input logic [2:0] k);
    case (k)
      3'd1, 3'd2: return 3'sd2;
      3'd0, 3'd3: return 3'sd1;
      3'd4, 3'd7: return -3'sd1;
      default:    return -3'sd2;
    endcase
  endfunction

  // State
  logic [31:0]             phase_q,   phase_d;
  logic [15:0]             cnt_q,     cnt_d;
  logic [15:0]             len_q,     len_d;
  logic signed [P_W-1:0]   i1_q,      i1_d;
  logic signed [P_W-1:0]   q1_q,      q1_d;
  logic                    chip_q,    chip_d;
  logic                    last_q,    last_d;
  logic                    v1_q,      v1_d;
  logic signed [ACC_W-1:0] acc_i_q,   acc_i_d;
  logic signed [ACC_W-1:0] acc_q_q,   acc_q_d;
  logic signed [ACC_W-1:0] i_dump_q,  i_dump_d;
  logic signed [ACC_W-1:0] q_dump_q,  q_dump_d;
  logic                    valid_q,   valid_d;
  logic                    overrun_q, overrun_d;

  // Combinational helpers
  logic [2:0]              k;
  logic signed [P_W-1:0]   re_x, im_x, cos_x, sin_x;
  logic [15:0]             eff_len;
  logic                    is_last;
  logic signed [ACC_W-1:0] term_i, term_q, sum_i, sum_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block free of inferred latches.
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    i1_d      = i1_q;
    q1_d      = q1_q;
    chip_d    = chip_q;
    last_d    = last_q;
    v1_d      = 1'b0;
    acc_i_d   = acc_i_q;
    acc_q_d   = acc_q_q;
    i_dump_d  = i_dump_q;
    q_dump_d  = q_dump_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    // Stage 1: carrier wipe-off of the incoming sample.
    k     = phase_q[31:29];
    re_x  = P_W'(real_in);
    im_x  = P_W'(imag_in);
    cos_x = P_W'(cos_lut(k));
    sin_x = P_W'(sin_lut(k));

    // The integration length is captured at the first sample of each
    // integration so a dump_len change never truncates one in flight.
    eff_len = (cnt_q == 16'd0) ? ((dump_len == 16'd0) ? 16'd1 : dump_len) : len_q;
    is_last = (cnt_q == eff_len - 16'd1);

    if (enable) begin
      phase_d = phase_q + freq;
      len_d   = eff_len;
      cnt_d   = is_last ? 16'd0 : cnt_q + 16'd1;
      i1_d    = re_x * cos_x + im_x * sin_x;
      q1_d    = im_x * cos_x - re_x * sin_x;
      chip_d  = (ca_sel < 6'd36) ? ca_seq[ca_sel] : 1'b0;
      last_d  = is_last;
      v1_d    = 1'b1;
    end

    // Stage 2: despread and integrate.
    term_i = ACC_W'(i1_q);
    term_q = ACC_W'(q1_q);
    if (chip_q) begin
      term_i = -term_i;
      term_q = -term_q;
    end
    sum_i = acc_i_q + term_i;
    sum_q = acc_q_q + term_q;

    if (v1_q && last_q) begin
      i_dump_d = sum_i;
      q_dump_d = sum_q;
      acc_i_d  = '0;
      acc_q_d  = '0;
      valid_d  = 1'b1;
      // A result accepted on this same edge is not lost, so no overrun then.
      if (valid_q && !dump.dump_ready) overrun_d = 1'b1;
    end else begin
      if (v1_q) begin
        acc_i_d = sum_i;
        acc_q_d = sum_q;
      end
      if (valid_q && dump.dump_ready) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop, independent of statement order.
    if (reset) begin
      phase_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      i1_q      <= '0;
      q1_q      <= '0;
      chip_q    <= 1'b0;
      last_q    <= 1'b0;
      v1_q      <= 1'b0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      i_dump_q  <= '0;
      q_dump_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      i1_q      <= i1_d;
      q1_q      <= q1_d;
      chip_q    <= chip_d;
      last_q    <= last_d;
      v1_q      <= v1_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      i_dump_q  <= i_dump_d;
      q_dump_q  <= q_dump_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign dump.i_dump     = i_dump_q;
  assign dump.q_dump     = q_dump_q;
  assign dump.dump_valid = valid_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_sat_corr.sv
// -----------------------------------------------------------------------------
// tb_sat_corr
// Self-checking bench for sat_corr. A small reference model runs alongside the
// stimulus and queues each expected dump; tasks pop and compare when the DUT
// presents the result.
// -----------------------------------------------------------------------------
module tb_sat_corr;
  localparam int IN_W  = 16;
  localparam int ACC_W = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic signed [IN_W-1:0] real_in;
  logic signed [IN_W-1:0] imag_in;
  logic [31:0]            freq;
  logic [35:0]            ca_seq;
  logic [5:0]             ca_sel;
  logic [15:0]            dump_len;
  logic                   overrun;

  sat_corr_if #(.ACC_W(ACC_W)) dump_if ();

  sat_corr #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .real_in  (real_in),
    .imag_in  (imag_in),
    .freq     (freq),
    .ca_seq   (ca_seq),
    .ca_sel   (ca_sel),
    .dump_len (dump_len),
    .dump     (dump_if),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int i;
    int q;
  } dump_t;

  dump_t exp_q[$];

  // Reference model state
  logic [31:0] m_phase;
  int          m_cnt, m_len, m_acc_i, m_acc_q;
  int          cos_tab [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
  int          sin_tab [8] = '{1, 2, 2, 1, -1, -2, -2, -1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_phase = '0;
    m_cnt   = 0;
    m_len   = 1;
    m_acc_i = 0;
    m_acc_q = 0;
    exp_q.delete();
  endtask

  function automatic dump_t pop_exp();
    dump_t d;
    d.i = 32'h0BAD_0BAD;
    d.q = 32'h0BAD_0BAD;
    if (exp_q.size() > 0) d = exp_q.pop_front();
    return d;
  endfunction

  task automatic apply_reset();
    reset  = 1'b1;
    enable = 1'b0;
    step();
    step();
    reset = 1'b0;
    model_reset();
  endtask

  // Present one sample for one edge and advance the model to match.
  task automatic sample(input int re, input int im);
    int k, ti, tq;
    enable  = 1'b1;
    real_in = 16'(re);
    imag_in = 16'(im);
    k  = int'(m_phase[31:29]);
    ti = re * cos_tab[k] + im * sin_tab[k];
    tq = im * cos_tab[k] - re * sin_tab[k];
    if (ca_seq[ca_sel]) begin
      ti = -ti;
      tq = -tq;
    end
    if (m_cnt == 0) m_len = (dump_len == 16'd0) ? 1 : int'(dump_len);
    m_acc_i += ti;
    m_acc_q += tq;
    if (m_cnt == m_len - 1) begin
      exp_q.push_back('{i: m_acc_i, q: m_acc_q});
      m_acc_i = 0;
      m_acc_q = 0;
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
    m_phase += freq;
    step();
  endtask

  task automatic idle();
    enable = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (dump_if.i_dump !== 32'sd0) begin
      failures++;
      $display("FAIL reset_i_dump got=%0d want=0", dump_if.i_dump);
    end
    checks++;
    if (dump_if.q_dump !== 32'sd0) begin
      failures++;
      $display("FAIL reset_q_dump got=%0d want=0", dump_if.q_dump);
    end
    checks++;
    if (dump_if.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", dump_if.dump_valid);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_overrun got=%b want=0", overrun);
    end
  endtask

  // Runs n identical samples, checks the one-edge latency, the dump, and the
  // handshake that retires it.
  task automatic run_integration(input string name, input int n, input int re, input int im);
    dump_t e;
    for (int s = 0; s < n; s++) sample(re, im);
    checks++;
    if (dump_if.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_valid got=%b want=0", name, dump_if.dump_valid);
    end
    idle();
    e = pop_exp();
    checks++;
    if (dump_if.dump_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_valid got=%b want=1", name, dump_if.dump_valid);
    end
    checks++;
    if (dump_if.i_dump !== e.i) begin
      failures++;
      $display("FAIL %s_i got=%0d want=%0d", name, dump_if.i_dump, e.i);
    end
    checks++;
    if (dump_if.q_dump !== e.q) begin
      failures++;
      $display("FAIL %s_q got=%0d want=%0d", name, dump_if.q_dump, e.q);
    end
    dump_if.dump_ready = 1'b1;
    step();
    dump_if.dump_ready = 1'b0;
    checks++;
    if (dump_if.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_handshake got=%b want=0", name, dump_if.dump_valid);
    end
  endtask

  task automatic test_basic();
    freq     = 32'd0;
    ca_sel   = 6'd1;
    dump_len = 16'd4;
    run_integration("basic", 4, 100, 0);
  endtask

  task automatic test_chip();
    ca_sel = 6'd35;
    run_integration("chip", 4, 100, 0);
    ca_sel = 6'd1;
  endtask

  task automatic test_carrier();
    freq     = 32'h2000_0000;
    dump_len = 16'd8;
    run_integration("carrier", 8, 1000, 0);
    freq = 32'd0;
  endtask

  task automatic test_overrun();
    dump_t e;
    dump_len = 16'd2;
    sample(10, -3);
    sample(20, 5);
    sample(30, 7);
    sample(-40, 11);
    idle();
    void'(pop_exp());
    e = pop_exp();
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got=%b want=1", overrun);
    end
    checks++;
    if (dump_if.dump_valid !== 1'b1) begin
      failures++;
      $display("FAIL overrun_valid got=%b want=1", dump_if.dump_valid);
    end
    checks++;
    if (dump_if.i_dump !== e.i || dump_if.q_dump !== e.q) begin
      failures++;
      $display("FAIL overrun_data got=%0d,%0d want=%0d,%0d",
               dump_if.i_dump, dump_if.q_dump, e.i, e.q);
    end
    dump_if.dump_ready = 1'b1;
    step();
    dump_if.dump_ready = 1'b0;
    checks++;
    if (dump_if.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL overrun_handshake got=%b want=0", dump_if.dump_valid);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got=%b want=1", overrun);
    end
  endtask

  task automatic test_reset_mid();
    dump_t e;
    dump_len = 16'd4;
    for (int s = 0; s < 3; s++) sample(50, 0);
    apply_reset();
    checks++;
    if (overrun !== 1'b0 || dump_if.dump_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear got=%b,%b want=0,0", overrun, dump_if.dump_valid);
    end
    for (int s = 0; s < 4; s++) begin
      sample(100, 0);
      checks++;
      if (dump_if.dump_valid !== 1'b0) begin
        failures++;
        $display("FAIL midreset_early_valid_%0d got=%b want=0", s, dump_if.dump_valid);
      end
    end
    idle();
    e = pop_exp();
    checks++;
    if (dump_if.dump_valid !== 1'b1 || dump_if.i_dump !== e.i || dump_if.q_dump !== e.q) begin
      failures++;
      $display("FAIL midreset_dump got=%b,%0d,%0d want=1,%0d,%0d",
               dump_if.dump_valid, dump_if.i_dump, dump_if.q_dump, e.i, e.q);
    end
    dump_if.dump_ready = 1'b1;
    step();
    dump_if.dump_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    dump_t e;
    dump_len           = 16'd1;
    dump_if.dump_ready = 1'b1;
    sample(1, 0);
    for (int s = 2; s <= 4; s++) begin
      if (s <= 3) sample(s, 0);
      else idle();
      e = pop_exp();
      checks++;
      if (dump_if.dump_valid !== 1'b1 || dump_if.i_dump !== e.i || dump_if.q_dump !== e.q) begin
        failures++;
        $display("FAIL b2b_dump_%0d got=%b,%0d,%0d want=1,%0d,%0d", s - 1,
                 dump_if.dump_valid, dump_if.i_dump, dump_if.q_dump, e.i, e.q);
      end
      checks++;
      if (overrun !== 1'b0) begin
        failures++;
        $display("FAIL b2b_overrun_%0d got=%b want=0", s - 1, overrun);
      end
    end
  endtask

  task automatic test_len_zero();
    dump_t e;
    dump_len           = 16'd0;
    dump_if.dump_ready = 1'b1;
    sample(7, 3);
    idle();
    e = pop_exp();
    checks++;
    if (dump_if.dump_valid !== 1'b1 || dump_if.i_dump !== e.i || dump_if.q_dump !== e.q) begin
      failures++;
      $display("FAIL len0_dump got=%b,%0d,%0d want=1,%0d,%0d",
               dump_if.dump_valid, dump_if.i_dump, dump_if.q_dump, e.i, e.q);
    end
    dump_if.dump_ready = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    enable             = 1'b0;
    real_in            = '0;
    imag_in            = '0;
    freq               = '0;
    ca_seq             = 36'h8_0000_0005;
    ca_sel             = 6'd1;
    dump_len           = 16'd4;
    dump_if.dump_ready = 1'b0;
    model_reset();

    test_reset();
    test_basic();
    test_chip();
    test_carrier();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_len_zero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1);
  end

endmodule
